// File: rtl/sump_cmd_parser.sv
// ---------------------------------------------------------------------------
// sump_cmd_parser
//
// Receive-side command decoder for the SUMP logic-analyzer link. Bytes from
// the UART receiver are decoded as SUMP short (1-byte) or long (opcode plus
// 4 payload bytes) commands. Short commands become one-cycle strobes or the
// xoff level. Long commands are assembled and presented as opcode + 32-bit
// payload. ID / metadata requests are handed to metadata_sender through a
// request/busy handshake.
//
// Ports
//   clock               system clock, all logic on posedge
//   reset_n             asynchronous active-low reset
//   rx_byte             received byte, qualified by rx_valid
//   rx_valid            one-cycle strobe per received byte
//   meta_busy           metadata_sender is transmitting
//   begin_meta_transmit request to metadata_sender, held until it goes busy
//   send_id             1 = ID request, 0 = metadata request
//   cmd_reset           pulse on short 0x00
//   cmd_arm             pulse on short 0x01
//   xoff                level, set by 0x13, cleared by 0x11 / 0x00
//   long_cmd_valid      pulse when a long command completes
//   long_cmd_opcode     opcode of the last completed long command
//   long_cmd_data       payload, first byte in [7:0], last byte in [31:24]
//   cmd_dropped         pulse, meta request ignored (one already outstanding)
//   cmd_unknown         pulse, unrecognised short opcode
//   long_timeout        pulse, partial long command abandoned
// ---------------------------------------------------------------------------
module sump_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned TIMEOUT_W      = 17
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   input  logic        meta_busy,
   output logic        begin_meta_transmit,
   output logic        send_id,
   output logic        cmd_reset,
   output logic        cmd_arm,
   output logic        xoff,
   output logic        long_cmd_valid,
   output logic [7:0]  long_cmd_opcode,
   output logic [31:0] long_cmd_data,
   output logic        cmd_dropped,
   output logic        cmd_unknown,
   output logic        long_timeout
);

   typedef enum logic {
      P_IDLE,
      P_LONG
   } parse_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_REQ,
      R_BUSY
   } req_state_e;

   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   parse_state_e        parseState_q, parseState_d;
   req_state_e          reqState_q, reqState_d;
   logic [1:0]          byteIdx_q, byteIdx_d;
   logic [TIMEOUT_W-1:0] timeoutCnt_q, timeoutCnt_d;
   logic [7:0]          opcodeLatch_q, opcodeLatch_d;
   // Only lanes 0..2 are buffered; lane 3 goes straight to the output register.
   logic [23:0]         payload_q, payload_d;
   logic                beginMeta_q, beginMeta_d;
   logic                sendId_q, sendId_d;
   logic                cmdReset_q, cmdReset_d;
   logic                cmdArm_q, cmdArm_d;
   logic                xoff_q, xoff_d;
   logic                longValid_q, longValid_d;
   logic [7:0]          longOpcode_q, longOpcode_d;
   logic [31:0]         longData_q, longData_d;
   logic                cmdDropped_q, cmdDropped_d;
   logic                cmdUnknown_q, cmdUnknown_d;
   logic                longTimeout_q, longTimeout_d;

   // State and output registers; everything returns to zero on reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         parseState_q  <= P_IDLE;
         reqState_q    <= R_IDLE;
         byteIdx_q     <= '0;
         timeoutCnt_q  <= '0;
         opcodeLatch_q <= '0;
         payload_q     <= '0;
         beginMeta_q   <= 1'b0;
         sendId_q      <= 1'b0;
         cmdReset_q    <= 1'b0;
         cmdArm_q      <= 1'b0;
         xoff_q        <= 1'b0;
         longValid_q   <= 1'b0;
         longOpcode_q  <= '0;
         longData_q    <= '0;
         cmdDropped_q  <= 1'b0;
         cmdUnknown_q  <= 1'b0;
         longTimeout_q <= 1'b0;
      end else begin
         parseState_q  <= parseState_d;
         reqState_q    <= reqState_d;
         byteIdx_q     <= byteIdx_d;
         timeoutCnt_q  <= timeoutCnt_d;
         opcodeLatch_q <= opcodeLatch_d;
         payload_q     <= payload_d;
         beginMeta_q   <= beginMeta_d;
         sendId_q      <= sendId_d;
         cmdReset_q    <= cmdReset_d;
         cmdArm_q      <= cmdArm_d;
         xoff_q        <= xoff_d;
         longValid_q   <= longValid_d;
         longOpcode_q  <= longOpcode_d;
         longData_q    <= longData_d;
         cmdDropped_q  <= cmdDropped_d;
         cmdUnknown_q  <= cmdUnknown_d;
         longTimeout_q <= longTimeout_d;
      end
   end

   // Next-state logic for both FSMs. The request handshake advances on its
   // own; the parser may start a new request only while the handshake is idle.
   always_comb begin
      parseState_d  = parseState_q;
      reqState_d    = reqState_q;
      byteIdx_d     = byteIdx_q;
      timeoutCnt_d  = timeoutCnt_q;
      opcodeLatch_d = opcodeLatch_q;
      payload_d     = payload_q;
      beginMeta_d   = beginMeta_q;
      sendId_d      = sendId_q;
      cmdReset_d    = 1'b0;
      cmdArm_d      = 1'b0;
      xoff_d        = xoff_q;
      longValid_d   = 1'b0;
      longOpcode_d  = longOpcode_q;
      longData_d    = longData_q;
      cmdDropped_d  = 1'b0;
      cmdUnknown_d  = 1'b0;
      longTimeout_d = 1'b0;

      // The sender acknowledges by going busy; once it goes quiet the next
      // request may be issued. The sender cannot be aborted, so nothing here
      // reacts to short 0x00.
      case (reqState_q)
         R_REQ: begin
            if (meta_busy) begin
               reqState_d  = R_BUSY;
               beginMeta_d = 1'b0;
            end
         end
         R_BUSY: begin
            if (!meta_busy) begin
               reqState_d = R_IDLE;
            end
         end
         default: ;
      endcase

      case (parseState_q)
         P_IDLE: begin
            if (rx_valid) begin
               if (rx_byte[7]) begin
                  opcodeLatch_d = rx_byte;
                  byteIdx_d     = '0;
                  timeoutCnt_d  = '0;
                  parseState_d  = P_LONG;
               end else begin
                  case (rx_byte)
                     8'h00: begin
                        cmdReset_d = 1'b1;
                        xoff_d     = 1'b0;
                     end
                     8'h01: cmdArm_d = 1'b1;
                     8'h02, 8'h04: begin
                        if (reqState_q == R_IDLE) begin
                           reqState_d  = R_REQ;
                           beginMeta_d = 1'b1;
                           sendId_d    = (rx_byte == 8'h02);
                        end else begin
                           cmdDropped_d = 1'b1;
                        end
                     end
                     8'h11: xoff_d = 1'b0;
                     8'h13: xoff_d = 1'b1;
                     default: cmdUnknown_d = 1'b1;
                  endcase
               end
            end
         end
         P_LONG: begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (rx_valid) begin
               timeoutCnt_d = '0;
               case (byteIdx_q)
                  2'd0: payload_d[7:0]   = rx_byte;
                  2'd1: payload_d[15:8]  = rx_byte;
                  2'd2: payload_d[23:16] = rx_byte;
                  default: ;
               endcase
               if (byteIdx_q == 2'd3) begin
                  longValid_d  = 1'b1;
                  longOpcode_d = opcodeLatch_q;
                  longData_d   = {rx_byte, payload_q};
                  parseState_d = P_IDLE;
               end else begin
                  byteIdx_d = byteIdx_q + 2'd1;
               end
            end else if (timeoutCnt_q == TIMEOUT_LAST) begin
               longTimeout_d = 1'b1;
               parseState_d  = P_IDLE;
            end else begin
               timeoutCnt_d = timeoutCnt_q + TIMEOUT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign begin_meta_transmit = beginMeta_q;
   assign send_id             = sendId_q;
   assign cmd_reset           = cmdReset_q;
   assign cmd_arm             = cmdArm_q;
   assign xoff                = xoff_q;
   assign long_cmd_valid      = longValid_q;
   assign long_cmd_opcode     = longOpcode_q;
   assign long_cmd_data       = longData_q;
   assign cmd_dropped         = cmdDropped_q;
   assign cmd_unknown         = cmdUnknown_q;
   assign long_timeout        = longTimeout_q;

endmodule

// File: tb/tb_sump_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_sump_cmd_parser
//
// Self-checking bench for sump_cmd_parser with a short timeout (16 cycles).
// Every cycle the full output bundle is compared against a behavioural model
// that keeps the long-command payload in a queue and counts idle cycles as a
// plain integer. A table of directed vectors, hand-written handshake, timeout
// and reset sequences, and a randomized run all drive the same model.
// ---------------------------------------------------------------------------
module tb_sump_cmd_parser;

   localparam int T_CYCLES = 16;
   localparam int T_W      = 5;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  rxByte;
   logic        rxValid;
   logic        metaBusy;
   logic        beginMeta;
   logic        sendId;
   logic        cmdReset;
   logic        cmdArm;
   logic        xoff;
   logic        longValid;
   logic [7:0]  longOpcode;
   logic [31:0] longData;
   logic        cmdDropped;
   logic        cmdUnknown;
   logic        longTimeout;

   int checks   = 0;
   int failures = 0;

   sump_cmd_parser #(
      .TIMEOUT_CYCLES(T_CYCLES),
      .TIMEOUT_W     (T_W)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .rx_byte            (rxByte),
      .rx_valid           (rxValid),
      .meta_busy          (metaBusy),
      .begin_meta_transmit(beginMeta),
      .send_id            (sendId),
      .cmd_reset          (cmdReset),
      .cmd_arm            (cmdArm),
      .xoff               (xoff),
      .long_cmd_valid     (longValid),
      .long_cmd_opcode    (longOpcode),
      .long_cmd_data      (longData),
      .cmd_dropped        (cmdDropped),
      .cmd_unknown        (cmdUnknown),
      .long_timeout       (longTimeout)
   );

   always #5 clock = ~clock;

   // Behavioural model state: a pending request, a sender that is busy, a
   // queue of collected payload bytes and the idle run since the last byte.
   bit         mPending;
   bit         mSenderBusy;
   bit         mInLong;
   logic [7:0] mOpcode;
   logic [7:0] mBytes[$];
   int         mIdle;

   logic        eBegin, eSendId, eReset, eArm, eXoff, eValid;
   logic [7:0]  eOpcode;
   logic [31:0] eData;
   logic        eDropped, eUnknown, eTimeout;

   function automatic void modelReset();
      mPending    = 1'b0;
      mSenderBusy = 1'b0;
      mInLong     = 1'b0;
      mOpcode     = 8'h00;
      mBytes.delete();
      mIdle       = 0;
      eBegin      = 1'b0;
      eSendId     = 1'b0;
      eReset      = 1'b0;
      eArm        = 1'b0;
      eXoff       = 1'b0;
      eValid      = 1'b0;
      eOpcode     = 8'h00;
      eData       = 32'h0;
      eDropped    = 1'b0;
      eUnknown    = 1'b0;
      eTimeout    = 1'b0;
   endfunction

   // One clock of the model: inputs seen this cycle, expectations for the next.
   function automatic void modelStep(input logic v, input logic [7:0] b, input logic mb);
      bit outstanding;
      outstanding = mPending || mSenderBusy;
      eReset   = 1'b0;
      eArm     = 1'b0;
      eValid   = 1'b0;
      eDropped = 1'b0;
      eUnknown = 1'b0;
      eTimeout = 1'b0;

      if (mPending && mb) begin
         mPending    = 1'b0;
         mSenderBusy = 1'b1;
      end else if (!mPending && mSenderBusy && !mb) begin
         mSenderBusy = 1'b0;
      end

      if (mInLong) begin
         if (v) begin
            mBytes.push_back(b);
            mIdle = 0;
            if (mBytes.size() == 4) begin
               eValid  = 1'b1;
               eOpcode = mOpcode;
               eData   = {mBytes[3], mBytes[2], mBytes[1], mBytes[0]};
               mInLong = 1'b0;
            end
         end else begin
            mIdle++;
            if (mIdle == T_CYCLES) begin
               eTimeout = 1'b1;
               mInLong  = 1'b0;
            end
         end
      end else if (v) begin
         if (b >= 8'h80) begin
            mInLong = 1'b1;
            mOpcode = b;
            mBytes.delete();
            mIdle   = 0;
         end else if (b == 8'h00) begin
            eReset = 1'b1;
            eXoff  = 1'b0;
         end else if (b == 8'h01) begin
            eArm = 1'b1;
         end else if (b == 8'h02 || b == 8'h04) begin
            if (outstanding) begin
               eDropped = 1'b1;
            end else begin
               mPending = 1'b1;
               eSendId  = (b == 8'h02);
            end
         end else if (b == 8'h11) begin
            eXoff = 1'b0;
         end else if (b == 8'h13) begin
            eXoff = 1'b1;
         end else begin
            eUnknown = 1'b1;
         end
      end
      eBegin = mPending;
   endfunction

   task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic expectBit(input string name, input logic actual, input logic expected);
      checkValue(name, {63'b0, actual}, {63'b0, expected});
   endtask

   // Whole output bundle against the model.
   task automatic checkOutput(input string name);
      checkValue(name,
         {15'b0, beginMeta, sendId, cmdReset, cmdArm, xoff, longValid, longOpcode, longData,
          cmdDropped, cmdUnknown, longTimeout},
         {15'b0, eBegin, eSendId, eReset, eArm, eXoff, eValid, eOpcode, eData,
          eDropped, eUnknown, eTimeout});
   endtask

   // Drive one cycle of inputs (called at posedge+1), clock it, compare at posedge+1.
   task automatic applyStimulus(input logic v, input logic [7:0] b, input logic mb);
      rxValid  = v;
      rxByte   = b;
      metaBusy = mb;
      modelStep(v, b, mb);
      @(posedge clock);
      #1;
      rxValid = 1'b0;
      rxByte  = 8'h00;
      checkOutput("bundle");
   endtask

   typedef struct {
      logic        v;
      logic [7:0]  b;
      logic        rst;
      logic        arm;
      logic        xo;
      logic        unk;
      logic        lv;
      logic [7:0]  op;
      logic [31:0] data;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [7:0] b, input logic rst, input logic arm,
                               input logic xo, input logic unk, input logic lv, input logic [7:0] op,
                               input logic [31:0] data);
      vec_t r;
      r.v = v; r.b = b; r.rst = rst; r.arm = arm; r.xo = xo;
      r.unk = unk; r.lv = lv; r.op = op; r.data = data;
      return r;
   endfunction

   vec_t vecs[20];

   initial begin
      logic mb;
      logic v;
      logic [7:0] b;
      int sel;
      logic [7:0] raceBytes[4];

      //            v  byte   rst arm xo unk lv  op     data
      vecs[0]  = mk(1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[1]  = mk(1, 8'h01, 0, 1, 0, 0, 0, 8'h00, 32'h0);
      vecs[2]  = mk(1, 8'h13, 0, 0, 1, 0, 0, 8'h00, 32'h0);
      vecs[3]  = mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 32'h0);
      vecs[4]  = mk(1, 8'h11, 0, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[5]  = mk(1, 8'h13, 0, 0, 1, 0, 0, 8'h00, 32'h0);
      vecs[6]  = mk(1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[7]  = mk(1, 8'h05, 0, 0, 0, 1, 0, 8'h00, 32'h0);
      vecs[8]  = mk(1, 8'hC0, 0, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[9]  = mk(1, 8'h78, 0, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[10] = mk(1, 8'h56, 0, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[11] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[12] = mk(1, 8'h34, 0, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[13] = mk(1, 8'h12, 0, 0, 0, 0, 1, 8'hC0, 32'h12345678);
      vecs[14] = mk(1, 8'h80, 0, 0, 0, 0, 0, 8'hC0, 32'h12345678);
      vecs[15] = mk(1, 8'h00, 0, 0, 0, 0, 0, 8'hC0, 32'h12345678);
      vecs[16] = mk(1, 8'h00, 0, 0, 0, 0, 0, 8'hC0, 32'h12345678);
      vecs[17] = mk(1, 8'h00, 0, 0, 0, 0, 0, 8'hC0, 32'h12345678);
      vecs[18] = mk(1, 8'h00, 0, 0, 0, 0, 1, 8'h80, 32'h00000000);
      vecs[19] = mk(1, 8'h01, 0, 1, 0, 0, 0, 8'h80, 32'h00000000);

      rxValid  = 1'b0;
      rxByte   = 8'h00;
      metaBusy = 1'b0;
      reset_n  = 1'b0;
      modelReset();
      repeat (2) @(posedge clock);
      #1;
      checkOutput("resetState");
      reset_n = 1'b1;

      $display("[TB] directed table");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].v, vecs[i].b, 1'b0);
         expectBit("tblReset", cmdReset, vecs[i].rst);
         expectBit("tblArm", cmdArm, vecs[i].arm);
         expectBit("tblXoff", xoff, vecs[i].xo);
         expectBit("tblUnknown", cmdUnknown, vecs[i].unk);
         expectBit("tblLongValid", longValid, vecs[i].lv);
         checkValue("tblOpcode", {56'b0, longOpcode}, {56'b0, vecs[i].op});
         checkValue("tblData", {32'b0, longData}, {32'b0, vecs[i].data});
      end

      $display("[TB] metadata handshake");
      applyStimulus(1'b1, 8'h02, 1'b0);
      expectBit("idBegin", beginMeta, 1'b1);
      expectBit("idSendId", sendId, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      expectBit("idBeginHeld1", beginMeta, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      expectBit("idBeginHeld2", beginMeta, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      expectBit("idBeginAck", beginMeta, 1'b0);
      for (int i = 0; i < 19; i++) begin
         if (i == 2) begin
            applyStimulus(1'b1, 8'h04, 1'b1);
            expectBit("busyDropped", cmdDropped, 1'b1);
            expectBit("busySendId", sendId, 1'b1);
         end else begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            expectBit("busyNoBegin", beginMeta, 1'b0);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h04, 1'b0);
      expectBit("metaBegin", beginMeta, 1'b1);
      expectBit("metaSendId", sendId, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b0);
      expectBit("reqDropped", cmdDropped, 1'b1);
      expectBit("reqSendId", sendId, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0);

      $display("[TB] long command timeout");
      applyStimulus(1'b1, 8'h80, 1'b0);
      applyStimulus(1'b1, 8'hAA, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0);
         expectBit("timeoutPulse", longTimeout, (i == 16));
      end
      checkValue("timeoutOpcodeKept", {56'b0, longOpcode}, 64'h80);
      checkValue("timeoutDataKept", {32'b0, longData}, 64'h0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      expectBit("armAfterTimeout", cmdArm, 1'b1);
      expectBit("timeoutCleared", longTimeout, 1'b0);

      $display("[TB] byte on expiry cycle");
      raceBytes[0] = 8'h11;
      raceBytes[1] = 8'h22;
      raceBytes[2] = 8'h33;
      raceBytes[3] = 8'h44;
      applyStimulus(1'b1, 8'h81, 1'b0);
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            expectBit("raceNoTimeout", longTimeout, 1'b0);
         end
         applyStimulus(1'b1, raceBytes[j], 1'b0);
         expectBit("raceNoTimeoutByte", longTimeout, 1'b0);
      end
      expectBit("raceValid", longValid, 1'b1);
      checkValue("raceOpcode", {56'b0, longOpcode}, 64'h81);
      checkValue("raceData", {32'b0, longData}, 64'h44332211);

      $display("[TB] asynchronous reset");
      applyStimulus(1'b1, 8'h02, 1'b0);
      applyStimulus(1'b1, 8'h83, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0);
      #2;
      reset_n = 1'b0;
      modelReset();
      #1;
      checkOutput("asyncReset");
      expectBit("asyncResetBegin", beginMeta, 1'b0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      applyStimulus(1'b1, 8'hC5, 1'b0);
      applyStimulus(1'b1, 8'hEF, 1'b0);
      applyStimulus(1'b1, 8'hBE, 1'b0);
      applyStimulus(1'b1, 8'hAD, 1'b0);
      applyStimulus(1'b1, 8'hDE, 1'b0);
      expectBit("postResetValid", longValid, 1'b1);
      checkValue("postResetOpcode", {56'b0, longOpcode}, 64'hC5);
      checkValue("postResetData", {32'b0, longData}, 64'hDEADBEEF);

      $display("[TB] randomized run");
      mb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (((i / 500) % 2) == 1) begin
            v = ($urandom_range(0, 39) == 0);
         end else begin
            v = $urandom_range(0, 1) == 1;
         end
         if ($urandom_range(0, 7) == 0) begin
            mb = ~mb;
         end
         sel = $urandom_range(0, 9);
         case (sel)
            0: b = 8'h00;
            1: b = 8'h01;
            2: b = 8'h02;
            3: b = 8'h04;
            4: b = 8'h11;
            5: b = 8'h13;
            6: b = 8'($urandom_range(0, 127));
            7, 8: b = 8'h80 | 8'($urandom_range(0, 127));
            default: b = 8'($urandom_range(0, 255));
         endcase
         applyStimulus(v, b, mb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sump_cmd_parser.md
Name: sump_cmd_parser

Overview:
- Receive-side counterpart of the metadata sender in the SUMP logic-analyzer link.
- Consumes bytes from the UART receiver and decodes SUMP short (1-byte) and long (5-byte) commands.
- Drives command strobes to the capture core and the data-register file.
- Issues the ID / query-metadata request handshake to metadata_sender (begin_meta_transmit, send_id, meta_busy).

Parameters:
TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of a long command before it is aborted
TIMEOUT_W, 17, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
clock  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous active-low reset
rx_byte  input  8  received byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
meta_busy  input  1  from metadata_sender; high while it transmits
begin_meta_transmit  output  1  request to metadata_sender, held until acknowledged
send_id  output  1  1=ID request, 0=metadata request; stable while request pending/busy
cmd_reset  output  1  one-cycle pulse on short 0x00
cmd_arm  output  1  one-cycle pulse on short 0x01
xoff  output  1  level; set by 0x13, cleared by 0x11 or 0x00
long_cmd_valid  output  1  one-cycle pulse, long command complete
long_cmd_opcode  output  8  opcode of last completed long command
long_cmd_data  output  32  payload, b0 in [7:0] ... b3 in [31:24]
cmd_dropped  output  1  one-cycle pulse, meta request ignored because one is outstanding
cmd_unknown  output  1  one-cycle pulse, unrecognised short opcode
long_timeout  output  1  one-cycle pulse, partial long command aborted

Behaviour:
- Reset (async, reset_n=0): all outputs 0; long_cmd_opcode and long_cmd_data = 0; both FSMs in IDLE; counters 0.
- All outputs are registered. A byte strobed in cycle N produces its response in cycle N+1.
- Parse FSM states: P_IDLE, P_LONG (2-bit byte index k=0..3).
- P_IDLE, rx_valid=1:
  - rx_byte[7]=1: latch opcode, k=0, clear timeout counter, go to P_LONG.
  - 0x00: cmd_reset pulse and xoff<=0.
  - 0x01: cmd_arm pulse.
  - 0x02: ID request (see request FSM).
  - 0x04: metadata request (see request FSM).
  - 0x11: xoff<=0.
  - 0x13: xoff<=1.
  - Any other short opcode: cmd_unknown pulse, no other effect.
- P_LONG, rx_valid=1:
  - Store the byte into data lane k and clear the timeout counter.
  - For k=3: in cycle N+1, long_cmd_valid=1 with long_cmd_opcode/long_cmd_data updated; return to P_IDLE.
  - Otherwise k<=k+1.
  - Payload bytes are never decoded as commands, including 0x00.
- P_LONG, rx_valid=0: counter increments.
  - When the counter equals TIMEOUT_CYCLES-1: long_timeout pulse, return to P_IDLE, partial payload discarded.
  - long_cmd_opcode/long_cmd_data keep their previous values on timeout.
- rx_valid in the same cycle the counter would expire: the byte wins and no timeout occurs.
- long_cmd_opcode/long_cmd_data change only together with long_cmd_valid and hold their value otherwise.
- Request FSM states: R_IDLE, R_REQ, R_BUSY.
  - R_IDLE on 0x02/0x04: send_id<=1 for 0x02 and 0 for 0x04, begin_meta_transmit<=1, go to R_REQ.
  - R_REQ: begin_meta_transmit held 1 until meta_busy=1 is sampled; then begin_meta_transmit<=0 and go to R_BUSY. No timeout applies, since the sender waits for its tx_busy to drop.
  - R_BUSY: wait for meta_busy=0, then go to R_IDLE.
  - send_id is unchanged in R_REQ and R_BUSY and retains its last value in R_IDLE.
  - 0x02/0x04 received while in R_REQ or R_BUSY: cmd_dropped pulse; no state or send_id change.
- Short 0x00 does not abort the request FSM, because the metadata sender cannot be aborted.
- Parse FSM and request FSM run independently; long commands decode normally during R_REQ/R_BUSY.
- Only one rx_valid can occur per cycle, so at most one command strobe fires per cycle.

Test Plan:
- Reset, then bytes 0x00, 0x01, 0x13, 0x11 -> cmd_reset, cmd_arm each pulse 1 cycle one clock after their byte; xoff goes 1 then 0; all other outputs stay 0.
- Long 0xC0,0x78,0x56,0x34,0x12 -> one long_cmd_valid pulse one clock after the last byte; opcode 0xC0, data 0x12345678. Repeat with payload 0x00,0x00,0x00,0x00 -> no cmd_reset pulses; data 0x00000000.
- Byte 0x02 with meta_busy model rising 3 cycles later and falling 20 cycles after that -> begin_meta_transmit high exactly until meta_busy is sampled high; send_id=1. Byte 0x04 during busy -> cmd_dropped pulse, send_id stays 1. Fresh 0x04 after busy ends -> send_id=0.
- TIMEOUT_CYCLES=16: 0x80,0xAA then silence -> long_timeout pulse after 16 idle cycles; previous opcode/data retained. A following 0x01 -> cmd_arm pulse.
- Byte 0x05 -> cmd_unknown pulse only. Assert reset_n=0 mid long command and during R_REQ -> all outputs 0 immediately; after release, a new full long command decodes correctly.
